// File: rtl/vdp_vram_arbiter_if.sv
// ---------------------------------------------------------------------------
// vdp_vram_arbiter_if
// Bundles every signal between the VDP requesters, the VRAM macro and the
// VRAM arbiter.
//   bg_*   : background tile fetcher (req/addr in, rdata out)
//   spr_*  : sprite fetcher (req/addr in, ack/rdata out)
//   cpu_*  : CPU data port (req/we/addr/wdata in, ack/rdata out)
//   vram_* : VRAM macro port (addr/we/wdata out of arbiter, rdata in)
// Modports:
//   slave  : the arbiter
//   master : requesters plus VRAM macro (the environment around the arbiter)
// ---------------------------------------------------------------------------
interface vdp_vram_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              bg_req;
  logic [ADDR_W-1:0] bg_addr;
  logic [DATA_W-1:0] bg_rdata;

  logic              spr_req;
  logic [ADDR_W-1:0] spr_addr;
  logic              spr_ack;
  logic [DATA_W-1:0] spr_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic [ADDR_W-1:0] vram_addr;
  logic              vram_we;
  logic [DATA_W-1:0] vram_wdata;
  logic [DATA_W-1:0] vram_rdata;

  modport slave (
    input  bg_req, bg_addr,
    output bg_rdata,
    input  spr_req, spr_addr,
    output spr_ack, spr_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    output vram_addr, vram_we, vram_wdata,
    input  vram_rdata
  );

  modport master (
    output bg_req, bg_addr,
    input  bg_rdata,
    output spr_req, spr_addr,
    input  spr_ack, spr_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    input  vram_addr, vram_we, vram_wdata,
    output vram_rdata
  );
endinterface

// File: rtl/vdp_vram_arbiter.sv
// ---------------------------------------------------------------------------
// vdp_vram_arbiter
// Shares the single VDP VRAM port between the background fetcher (absolute
// priority), the sprite fetcher and the CPU data port (round-robin between
// the two on cycles the background leaves free). The chosen access is
// registered onto the VRAM port; a two-stage owner tag follows it so the read
// data (valid two cycles after the grant) is routed back to its requester.
// Ports:
//   clk   : VDP pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : vdp_vram_arbiter_if.slave (requesters + VRAM macro signals)
// ---------------------------------------------------------------------------
module vdp_vram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vdp_vram_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BG   = 2'd1,
    OWN_SPR  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    REQ_IDLE   = 2'd0,
    REQ_ISSUED = 2'd1,
    REQ_ACK    = 2'd2
  } req_state_e;

  // rr_last encoding: which of sprite/CPU received the most recent grant
  localparam logic RR_SPR = 1'b0;
  localparam logic RR_CPU = 1'b1;

  // Per-requester vectors: index 0 = sprite, index 1 = CPU
  logic [1:0]             req_v;
  logic [1:0]             busy_v;
  logic [1:0]             elig_v;
  logic [1:0]             grant_v;
  logic [1:0]             ack_v;
  logic [1:0][DATA_W-1:0] rdata_v;

  owner_e grant_owner;
  owner_e tag1_q, tag2_q;
  logic   wr2_q;
  logic   rr_last_q, rr_last_d;

  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic              vram_we_q, vram_we_d;
  logic [DATA_W-1:0] vram_wdata_q, vram_wdata_d;

  assign req_v  = {bus.cpu_req, bus.spr_req};
  assign elig_v = req_v & ~busy_v;

  // Grant decision: background first, then round-robin sprite/CPU.
  always_comb begin
    grant_owner = OWN_NONE;
    rr_last_d   = rr_last_q;
    if (bus.bg_req) begin
      grant_owner = OWN_BG;
    end else if (elig_v[0] && elig_v[1]) begin
      grant_owner = (rr_last_q == RR_CPU) ? OWN_SPR : OWN_CPU;
    end else if (elig_v[0]) begin
      grant_owner = OWN_SPR;
    end else if (elig_v[1]) begin
      grant_owner = OWN_CPU;
    end
    // Background grants leave the round-robin pointer untouched.
    if (grant_owner == OWN_SPR) begin
      rr_last_d = RR_SPR;
    end else if (grant_owner == OWN_CPU) begin
      rr_last_d = RR_CPU;
    end
  end

  assign grant_v = {grant_owner == OWN_CPU, grant_owner == OWN_SPR};

  // Next VRAM port contents; idle cycles drive all zeros.
  always_comb begin
    vram_addr_d  = '0;
    vram_we_d    = 1'b0;
    vram_wdata_d = '0;
    case (grant_owner)
      OWN_BG:  vram_addr_d = bus.bg_addr;
      OWN_SPR: vram_addr_d = bus.spr_addr;
      OWN_CPU: begin
        vram_addr_d  = bus.cpu_addr;
        vram_we_d    = bus.cpu_we;
        vram_wdata_d = bus.cpu_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_addr_q  <= '0;
      vram_we_q    <= 1'b0;
      vram_wdata_q <= '0;
      tag1_q       <= OWN_NONE;
      tag2_q       <= OWN_NONE;
      wr2_q        <= 1'b0;
      rr_last_q    <= RR_CPU;
    end else begin
      vram_addr_q  <= vram_addr_d;
      vram_we_q    <= vram_we_d;
      vram_wdata_q <= vram_wdata_d;
      tag1_q       <= grant_owner;
      tag2_q       <= tag1_q;
      wr2_q        <= vram_we_q;
      rr_last_q    <= rr_last_d;
    end
  end

  // Per-requester handshake FSM and read-data return path.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      localparam owner_e OWN_TAG = (gi == 0) ? OWN_SPR : OWN_CPU;

      req_state_e        state_q, state_d;
      logic [DATA_W-1:0] rdata_hold_q;
      logic              capture;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= REQ_IDLE;
        end else begin
          state_q <= state_d;
        end
      end

      // ISSUED advances when the tag enters stage 2 on the next edge, so
      // ACK lines up with the returning read data.
      always_comb begin
        state_d = state_q;
        case (state_q)
          REQ_IDLE:   if (grant_v[gi]) state_d = REQ_ISSUED;
          REQ_ISSUED: if (tag1_q == OWN_TAG) state_d = REQ_ACK;
          REQ_ACK:    state_d = REQ_IDLE;
          default:    state_d = REQ_IDLE;
        endcase
      end

      // Busy stays set through ACK so a request presented in the ACK cycle
      // waits one more cycle instead of issuing twice.
      assign busy_v[gi] = (state_q != REQ_IDLE);
      assign ack_v[gi]  = (state_q == REQ_ACK);

      // Writes return no data; the previous read value is kept.
      assign capture = (tag2_q == OWN_TAG) && !wr2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_hold_q <= '0;
        end else if (capture) begin
          rdata_hold_q <= bus.vram_rdata;
        end
      end

      // Bypass so the data is visible in the ack cycle itself.
      assign rdata_v[gi] = capture ? bus.vram_rdata : rdata_hold_q;
    end
  endgenerate

  assign bus.bg_rdata   = bus.vram_rdata;
  assign bus.spr_ack    = ack_v[0];
  assign bus.spr_rdata  = rdata_v[0];
  assign bus.cpu_ack    = ack_v[1];
  assign bus.cpu_rdata  = rdata_v[1];
  assign bus.vram_addr  = vram_addr_q;
  assign bus.vram_we    = vram_we_q;
  assign bus.vram_wdata = vram_wdata_q;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vdp_vram_arbiter
// Directed bench for vdp_vram_arbiter. Inputs are driven and outputs checked
// on the falling clock edge; a small synchronous VRAM stand-in answers the
// arbiter's port with one cycle of read latency. Unwritten locations read as
// addr[7:0] ^ addr[13:8].
// ---------------------------------------------------------------------------
module tb_vdp_vram_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  vdp_vram_arbiter_if #(.ADDR_W(14), .DATA_W(8)) bus ();

  vdp_vram_arbiter #(.ADDR_W(14), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // VRAM stand-in
  logic [7:0] mem [16384];
  bit         written [16384];

  function automatic logic [7:0] rd_val(input logic [13:0] a);
    if (written[a]) return mem[a];
    return a[7:0] ^ {2'b00, a[13:8]};
  endfunction

  always @(posedge clk) begin
    if (bus.vram_we) begin
      mem[bus.vram_addr]     <= bus.vram_wdata;
      written[bus.vram_addr] <= 1'b1;
    end
    bus.vram_rdata <= rd_val(bus.vram_addr);
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic count_acks(inout int sa, inout int ca);
    if (bus.spr_ack) begin
      sa++;
      chk("t5_spr_rdata", 32'(bus.spr_rdata), 32'h05);
    end
    if (bus.cpu_ack) begin
      ca++;
      chk("t5_cpu_rdata", 32'(bus.cpu_rdata), 32'h06);
    end
  endtask

  initial begin
    int          spr_acks;
    int          cpu_acks;
    logic [13:0] exp_a;
    bit          nxt_cpu;

    rst_n         = 1'b0;
    bus.bg_req    = 1'b0;
    bus.bg_addr   = '0;
    bus.spr_req   = 1'b0;
    bus.spr_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;

    // ---- reset state
    repeat (3) tick();
    chk("rst_vram_addr",  32'(bus.vram_addr),  32'h0);
    chk("rst_vram_we",    32'(bus.vram_we),    32'h0);
    chk("rst_vram_wdata", 32'(bus.vram_wdata), 32'h0);
    chk("rst_spr_ack",    32'(bus.spr_ack),    32'h0);
    chk("rst_cpu_ack",    32'(bus.cpu_ack),    32'h0);
    chk("rst_spr_rdata",  32'(bus.spr_rdata),  32'h0);
    chk("rst_cpu_rdata",  32'(bus.cpu_rdata),  32'h0);
    rst_n = 1'b1;
    tick();

    // ---- T1: lone CPU read of 0x1234 (expected data 0x34^0x12 = 0x26)
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h1234;
    tick();
    $display("t1: cpu read issued, vram_addr=%h", bus.vram_addr);
    chk("t1_addr_n1", 32'(bus.vram_addr), 32'h1234);
    chk("t1_we_n1",   32'(bus.vram_we),   32'h0);
    chk("t1_ack_n1",  32'(bus.cpu_ack),   32'h0);
    tick();
    chk("t1_ack_n2",   32'(bus.cpu_ack),   32'h1);
    chk("t1_rdata_n2", 32'(bus.cpu_rdata), 32'h26);
    bus.cpu_req = 1'b0;
    tick();
    chk("t1_ack_n3",   32'(bus.cpu_ack),   32'h0);
    chk("t1_rdata_hold", 32'(bus.cpu_rdata), 32'h26);

    // ---- T2: background held 6 cycles, CPU read 0x0200 waiting
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0200;
    for (int k = 0; k < 6; k++) begin
      bus.bg_req  = 1'b1;
      bus.bg_addr = 14'h0100 + 14'(k);
      tick();
      $display("t2: bg cycle %0d vram_addr=%h", k, bus.vram_addr);
      chk("t2_bg_addr", 32'(bus.vram_addr), 32'h0100 + 32'(k));
      chk("t2_bg_we",   32'(bus.vram_we),   32'h0);
      chk("t2_no_ack",  32'(bus.cpu_ack),   32'h0);
      if (k > 0) chk("t2_bg_rdata", 32'(bus.bg_rdata), 32'((k - 1) ^ 1));
    end
    bus.bg_req = 1'b0;
    tick();
    chk("t2_cpu_addr", 32'(bus.vram_addr), 32'h0200);
    tick();
    chk("t2_cpu_ack",   32'(bus.cpu_ack),   32'h1);
    chk("t2_cpu_rdata", 32'(bus.cpu_rdata), 32'h02);
    bus.cpu_req = 1'b0;

    // ---- T3: simultaneous sprite/CPU after reset -> sprite first
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.spr_req = 1'b1; bus.spr_addr = 14'h0300;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0400;
    tick();
    $display("t3: pair 1 first grant vram_addr=%h", bus.vram_addr);
    chk("t3_first_spr", 32'(bus.vram_addr), 32'h0300);
    tick();
    chk("t3_then_cpu",   32'(bus.vram_addr), 32'h0400);
    chk("t3_spr_ack",    32'(bus.spr_ack),   32'h1);
    chk("t3_spr_rdata",  32'(bus.spr_rdata), 32'h03);
    bus.spr_req = 1'b0;
    tick();
    chk("t3_cpu_ack",    32'(bus.cpu_ack),   32'h1);
    chk("t3_cpu_rdata",  32'(bus.cpu_rdata), 32'h04);
    chk("t3_spr_ack_lo", 32'(bus.spr_ack),   32'h0);
    bus.cpu_req = 1'b0;
    // lone sprite read leaves the sprite as the last one granted
    bus.spr_req = 1'b1; bus.spr_addr = 14'h0800;
    tick();
    chk("t3_lone_spr", 32'(bus.vram_addr), 32'h0800);
    tick();
    chk("t3_lone_ack", 32'(bus.spr_ack), 32'h1);
    bus.spr_req = 1'b0;
    tick();
    // second pair: CPU wins this time
    bus.spr_req = 1'b1; bus.spr_addr = 14'h0A00;
    bus.cpu_req = 1'b1; bus.cpu_addr = 14'h0900;
    tick();
    $display("t3: pair 2 first grant vram_addr=%h", bus.vram_addr);
    chk("t3_pair2_cpu", 32'(bus.vram_addr), 32'h0900);
    tick();
    chk("t3_pair2_spr", 32'(bus.vram_addr), 32'h0A00);
    chk("t3_pair2_cack", 32'(bus.cpu_ack), 32'h1);
    bus.cpu_req = 1'b0;
    tick();
    chk("t3_pair2_sack", 32'(bus.spr_ack), 32'h1);
    bus.spr_req = 1'b0;
    tick();

    // ---- T4: CPU write 0x3FFF=0xA5, then read it back
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h3FFF; bus.cpu_wdata = 8'hA5;
    tick();
    $display("t4: write we=%b wdata=%h addr=%h", bus.vram_we, bus.vram_wdata, bus.vram_addr);
    chk("t4_wr_addr",  32'(bus.vram_addr),  32'h3FFF);
    chk("t4_wr_we",    32'(bus.vram_we),    32'h1);
    chk("t4_wr_wdata", 32'(bus.vram_wdata), 32'hA5);
    tick();
    chk("t4_wr_ack", 32'(bus.cpu_ack), 32'h1);
    bus.cpu_we = 1'b0; bus.cpu_wdata = 8'h00;   // new read request in the ACK cycle
    tick();
    chk("t4_wr_ack_once", 32'(bus.cpu_ack),   32'h0);
    chk("t4_no_reissue",  32'(bus.vram_addr), 32'h0);
    tick();
    chk("t4_rd_addr", 32'(bus.vram_addr), 32'h3FFF);
    chk("t4_rd_we",   32'(bus.vram_we),   32'h0);
    tick();
    $display("t4: read back cpu_ack=%b cpu_rdata=%h", bus.cpu_ack, bus.cpu_rdata);
    chk("t4_rd_ack",   32'(bus.cpu_ack),   32'h1);
    chk("t4_rd_rdata", 32'(bus.cpu_rdata), 32'hA5);
    bus.cpu_req = 1'b0;
    tick();
    chk("t4_rd_ack_once", 32'(bus.cpu_ack), 32'h0);

    // ---- T5: background on columns 0,1,3,4,5,6; sprite and CPU always asking
    spr_acks = 0;
    cpu_acks = 0;
    nxt_cpu  = 1'b0;
    exp_a    = '0;
    bus.spr_req = 1'b1; bus.spr_addr = 14'h0500;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0600;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) begin
        chk("t5_slot_addr", 32'(bus.vram_addr), 32'(exp_a));
        chk("t5_slot_we",   32'(bus.vram_we),   32'h0);
      end
      count_acks(spr_acks, cpu_acks);
      bus.bg_req  = ((c % 8) != 2) && ((c % 8) != 7);
      bus.bg_addr = 14'h0700 + 14'(c);
      if (bus.bg_req) begin
        exp_a = 14'h0700 + 14'(c);
      end else begin
        exp_a   = nxt_cpu ? 14'h0600 : 14'h0500;
        nxt_cpu = !nxt_cpu;
      end
      tick();
    end
    chk("t5_slot_addr", 32'(bus.vram_addr), 32'(exp_a));
    count_acks(spr_acks, cpu_acks);
    bus.bg_req = 1'b0; bus.spr_req = 1'b0; bus.cpu_req = 1'b0;
    tick();
    count_acks(spr_acks, cpu_acks);
    tick();
    count_acks(spr_acks, cpu_acks);
    $display("t5: spr_acks=%0d cpu_acks=%0d", spr_acks, cpu_acks);
    chk("t5_spr_ack_cnt", 32'(spr_acks), 32'd4);
    chk("t5_cpu_ack_cnt", 32'(cpu_acks), 32'd4);

    // ---- T6: reset one cycle after a CPU grant
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h1234;
    tick();
    chk("t6_granted", 32'(bus.vram_addr), 32'h1234);
    rst_n = 1'b0;
    #1;
    $display("t6: in reset vram_addr=%h cpu_ack=%b", bus.vram_addr, bus.cpu_ack);
    chk("t6_rst_addr",  32'(bus.vram_addr),  32'h0);
    chk("t6_rst_we",    32'(bus.vram_we),    32'h0);
    chk("t6_rst_wdata", 32'(bus.vram_wdata), 32'h0);
    chk("t6_rst_cack",  32'(bus.cpu_ack),    32'h0);
    chk("t6_rst_sack",  32'(bus.spr_ack),    32'h0);
    chk("t6_rst_crd",   32'(bus.cpu_rdata),  32'h0);
    chk("t6_rst_srd",   32'(bus.spr_rdata),  32'h0);
    bus.cpu_req = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_no_stale_ack", 32'(bus.cpu_ack),   32'h0);
      chk("t6_idle_addr",    32'(bus.vram_addr), 32'h0);
    end
    bus.cpu_req = 1'b1; bus.cpu_addr = 14'h0200;
    tick();
    tick();
    chk("t6_new_ack",   32'(bus.cpu_ack),   32'h1);
    chk("t6_new_rdata", 32'(bus.cpu_rdata), 32'h02);
    bus.cpu_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
